// File: rtl/icache_axi_rd_bridge.sv
// I-cache refill responder: one AXI4 INCR read burst on a 32-bit bus per request,
// beats assembled into a 128-bit line returned as a single ret_valid pulse.
module icache_axi_rd_bridge #(
  parameter int unsigned      ID_W = 4,
  parameter logic [ID_W-1:0] ARID = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [31:0]       rd_addr,
  input  logic [7:0]        rd_len,
  output logic              ret_valid,
  output logic [127:0]      ret_data,
  output logic              rd_err,
  output logic [ID_W-1:0]   arid,
  output logic [31:0]       araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned BEAT_W = 32;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_RET  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                ret_valid_q, ret_valid_d;
  logic                rd_err_q, rd_err_d;
  logic [LINE_W-1:0]   ret_data_q, ret_data_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [LEN_W-1:0]    arlen_q, arlen_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                cancel_q, cancel_d;
  logic                beat_c;
  logic                unused_rid;

  // rid is not checked; single outstanding transaction with a fixed ID
  assign unused_rid = ^rid;

  assign beat_c = rvalid & rready_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    ret_valid_d = 1'b0;
    rd_err_d    = 1'b0;
    ret_data_d  = ret_data_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    cancel_d    = cancel_q;

    unique case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          araddr_d   = rd_addr;
          arlen_d    = rd_len;
          ret_data_d = '0;
          cnt_d      = '0;
          err_d      = 1'b0;
          cancel_d   = 1'b0;
          arvalid_d  = 1'b1;
          state_d    = S_AR;
        end
      end

      S_AR: begin
        if (!rd_req) begin
          cancel_d = 1'b1;
        end
        // arvalid is never withdrawn, even when the request is cancelled
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end
      end

      S_R: begin
        if (!rd_req) begin
          cancel_d = 1'b1;
        end
        if (beat_c) begin
          ret_data_d[{cnt_q, 5'd0} +: BEAT_W] = rdata;
          if (cnt_q != CNT_W'(3)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (rresp != 2'b00) begin
            err_d = 1'b1;
          end
          // rlast alone closes the burst; beat count is not checked against arlen
          if (rlast) begin
            rready_d    = 1'b0;
            ret_valid_d = ~cancel_d;
            rd_err_d    = err_d & ~cancel_d;
            state_d     = S_RET;
          end
        end
      end

      S_RET: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      ret_valid_q <= 1'b0;
      rd_err_q    <= 1'b0;
      ret_data_q  <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      cancel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      ret_valid_q <= ret_valid_d;
      rd_err_q    <= rd_err_d;
      ret_data_q  <= ret_data_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      cancel_q    <= cancel_d;
    end
  end

  assign ret_valid = ret_valid_q;
  assign ret_data  = ret_data_q;
  assign rd_err    = rd_err_q;
  assign arid      = ARID;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arsize    = 3'b010;
  assign arburst   = 2'b01;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Bench for icache_axi_rd_bridge: directed scenarios plus randomized transactions
// checked against a transaction-level model (lane assembly, error OR, cancel).
module tb_icache_axi_rd_bridge;

  logic         clk;
  logic         rst;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic [7:0]   rd_len;
  logic         ret_valid;
  logic [127:0] ret_data;
  logic         rd_err;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  icache_axi_rd_bridge #(.ID_W(4), .ARID(4'd0)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .ret_valid(ret_valid), .ret_data(ret_data), .rd_err(rd_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0]  bd[16];
  logic [1:0]   br[16];
  logic [127:0] exp_dq[$];
  logic         exp_eq[$];
  logic [31:0]  cur_addr = '0;
  logic [7:0]   cur_len  = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Cycle-by-cycle compare against the expected-return queue and AXI address rules
  logic         prev_arv = 1'b0, prev_ard = 1'b0, prev_ret = 1'b0, holding = 1'b0;
  logic [127:0] hold_val = '0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_arv = 1'b0;
      prev_ard = 1'b0;
      prev_ret = 1'b0;
      holding  = 1'b0;
    end else begin
      if (prev_arv && !prev_ard) chk("arvalid_held", arvalid, 1'b1);
      if (arvalid) begin
        chk("araddr", araddr, cur_addr);
        chk("arlen", arlen, cur_len);
        chk("arid", arid, 4'd0);
        chk("arsize", arsize, 3'b010);
        chk("arburst", arburst, 2'b01);
      end
      if (ret_valid) begin
        chk("ret_pulse_width", prev_ret, 1'b0);
        if (exp_dq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ret act=ret_valid exp=no_return data=%h", ret_data);
        end else begin
          hold_val = exp_dq.pop_front();
          chk("ret_data", ret_data, hold_val);
          chk("rd_err", rd_err, exp_eq.pop_front());
          holding = 1'b1;
        end
      end else begin
        chk("rd_err_without_ret", rd_err, 1'b0);
        if (holding) chk("ret_data_hold", ret_data, hold_val);
      end
      if (rd_req) holding = 1'b0;
      prev_arv = arvalid;
      prev_ard = arready;
      prev_ret = ret_valid;
    end
  end

  // One request acting as both cache and slave; cancel_at: -1 none, 100 in AR, k before beat k
  task automatic run_txn(input logic [31:0] a, input logic [7:0] l, input int nb,
                         input int ar_wait, input int gap, input int cancel_at,
                         input bit keep_req, input bit use_lit,
                         input logic [127:0] lit_data, input logic lit_err);
    logic [127:0] m;
    logic         e;
    bit           hs;
    int           w;
    int           lane;
    m = '0;
    e = 1'b0;
    for (int i = 0; i < nb; i++) begin
      lane = (i > 3) ? 3 : i;
      m[lane*32 +: 32] = bd[i];
      e = e | (br[i] != 2'b00);
    end
    if (use_lit) begin
      m = lit_data;
      e = lit_err;
    end
    if (cancel_at < 0) begin
      exp_dq.push_back(m);
      exp_eq.push_back(e);
    end
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = a; rd_len = l; cur_addr = a; cur_len = l;
    arready = (ar_wait == 0);
    @(negedge clk); chk("arvalid_before_accept", arvalid, 1'b0);
    @(posedge clk); #1;
    if (cancel_at == 100) rd_req = 1'b0;
    @(negedge clk); chk("ar_latency", arvalid, 1'b1);
    hs = 1'b0;
    w  = 0;
    for (int k = 0; k < 64; k++) begin
      hs = arvalid && arready;
      @(posedge clk); #1;
      if (hs) break;
      w++;
      arready = (w >= ar_wait);
      @(negedge clk);
    end
    if (!hs) chk("ar_handshake_timeout", 1'b0, 1'b1);
    arready = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i > 0) repeat (gap) begin @(posedge clk); #1; end
      if (cancel_at == i) rd_req = 1'b0;
      rvalid = 1'b1; rdata = bd[i]; rresp = br[i]; rlast = (i == nb - 1);
      hs = 1'b0;
      for (int k = 0; k < 64; k++) begin
        @(negedge clk);
        if (k == 0) chk("rready_in_burst", rready, 1'b1);
        hs = rready;
        @(posedge clk); #1;
        if (hs) break;
      end
      if (!hs) chk("r_handshake_timeout", 1'b0, 1'b1);
      rvalid = 1'b0;
      rlast  = 1'b0;
    end
    @(negedge clk); chk("ret_latency", ret_valid, (cancel_at < 0));
    if (!keep_req) rd_req = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int len, nb, ca;
    bit keep;
    rst = 1'b0; rd_req = 1'b0; rd_addr = '0; rd_len = '0; arready = 1'b0;
    rid = 4'd5; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    #1;
    chk("reset_arvalid", arvalid, 1'b0);
    chk("reset_rready", rready, 1'b0);
    chk("reset_ret_valid", ret_valid, 1'b0);
    chk("reset_rd_err", rd_err, 1'b0);
    chk("reset_ret_data", ret_data, 128'd0);
    chk("reset_araddr", araddr, 32'd0);
    chk("reset_arlen", arlen, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    bd[0] = 32'h11; bd[1] = 32'h22; bd[2] = 32'h33; bd[3] = 32'h44;
    for (int i = 0; i < 4; i++) br[i] = 2'b00;
    run_txn(32'h1FC0_0010, 8'h3, 4, 0, 0, -1, 1'b0, 1'b1,
            128'h00000044_00000033_00000022_00000011, 1'b0);

    bd[0] = 32'hDEADBEEF; br[0] = 2'b00;
    run_txn(32'hBFC0_0004, 8'h0, 1, 0, 0, -1, 1'b0, 1'b1, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF, 1'b0);

    bd[0] = 32'h11; bd[1] = 32'h22; bd[2] = 32'h33; bd[3] = 32'h44;
    run_txn(32'h1FC0_0010, 8'h3, 4, 5, 2, -1, 1'b0, 1'b1,
            128'h00000044_00000033_00000022_00000011, 1'b0);

    bd[0] = 32'hA0; bd[1] = 32'hA1; bd[2] = 32'hA2; bd[3] = 32'hA3;
    run_txn(32'h0000_1000, 8'h3, 4, 0, 1, 2, 1'b0, 1'b0, '0, 1'b0);
    bd[0] = 32'hB0; bd[1] = 32'hB1; bd[2] = 32'hB2; bd[3] = 32'hB3;
    run_txn(32'h0000_2000, 8'h3, 4, 0, 0, -1, 1'b0, 1'b1,
            128'h000000B3_000000B2_000000B1_000000B0, 1'b0);

    bd[0] = 32'hC0; bd[1] = 32'hC1; bd[2] = 32'hC2; bd[3] = 32'hC3; br[2] = 2'b10;
    run_txn(32'h0000_3000, 8'h3, 4, 0, 0, -1, 1'b1, 1'b1,
            128'h000000C3_000000C2_000000C1_000000C0, 1'b1);
    br[2] = 2'b00;
    bd[0] = 32'h5555_AAAA;
    run_txn(32'h0000_3010, 8'h0, 1, 0, 0, -1, 1'b0, 1'b1, 128'h5555_AAAA, 1'b0);

    // Asynchronous reset while in the data phase
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = 32'h0000_4000; rd_len = 8'h3; cur_addr = 32'h0000_4000; cur_len = 8'h3;
    arready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00; rlast = 1'b0;
    @(posedge clk); #1;
    rvalid = 1'b0;
    chk("pre_reset_rready", rready, 1'b1);
    #2;
    rst = 1'b0; rd_req = 1'b0;
    #1;
    chk("async_reset_arvalid", arvalid, 1'b0);
    chk("async_reset_rready", rready, 1'b0);
    chk("async_reset_ret_valid", ret_valid, 1'b0);
    chk("async_reset_rd_err", rd_err, 1'b0);
    chk("async_reset_ret_data", ret_data, 128'd0);
    chk("async_reset_araddr", araddr, 32'd0);
    chk("async_reset_arlen", arlen, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bd[0] = 32'hD0; bd[1] = 32'hD1; bd[2] = 32'hD2; bd[3] = 32'hD3;
    run_txn(32'h0000_5000, 8'h3, 4, 1, 0, -1, 1'b0, 1'b1,
            128'h000000D3_000000D2_000000D1_000000D0, 1'b0);

    for (int t = 0; t < 150; t++) begin
      int sel;
      sel = $urandom_range(0, 9);
      len = (sel < 5) ? 3 : (sel < 8) ? 0 : (sel == 8) ? 1 : 7;
      nb  = len + 1;
      for (int i = 0; i < nb; i++) begin
        bd[i] = $urandom;
        br[i] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      ca = -1;
      if ($urandom_range(0, 7) == 0) ca = ($urandom_range(0, 1) == 1) ? 100 : $urandom_range(0, nb - 1);
      keep = ($urandom_range(0, 1) == 1) && (ca < 0);
      run_txn($urandom & 32'hFFFF_FFF0, 8'(len), nb, $urandom_range(0, 3),
              $urandom_range(0, 2), ca, keep, 1'b0, '0, 1'b0);
      if (!keep) repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    chk("expected_queue_drained", 128'(exp_dq.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
